tpu_job_seq: RTL and testbench
==============================

TPU_JOB_SEQ -- requirements
Module: tpu_job_seq

Interface
REQ-001 Parameter DIM, 8, systolic array dimension; one A/B row per 64-bit beat; 2*DIM C words.
REQ-002 Parameter ADDRW, 16, TPU address width.
REQ-003 Parameter DATAW, 64, TPU and stream data width.
REQ-004 Parameter COMP_CYC, 3*DIM-1, idle cycles after the start write before the first C read.
REQ-005 Parameter RD_LAT, 1, cycles between presenting a read address and sampling tpu_dataOut.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle job request; honoured only in IDLE.
REQ-009 load_c  in  1  sampled with start; 1 = C initial values come from the stream, 0 = C is zero-filled.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse after the last C word is accepted downstream.
REQ-012 in_valid / in_ready / in_data  in / out / in  1 / 1 / DATAW  operand stream (valid/ready).
REQ-013 out_valid / out_ready / out_data  out / in / out  1 / 1 / DATAW  result stream (valid/ready).
REQ-014 tpu_r_w / tpu_addr / tpu_dataIn  out  1 / ADDRW / DATAW  registered TPU command port; r_w=1 is a write.
REQ-015 tpu_dataOut  in  DATAW  TPU read data.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, LOAD_C, ZERO_C, KICK, WAIT, RD_ADDR, RD_OUT and DONE.
REQ-017 IDLE: on start, latch load_c and go to LOAD_A; start in any other state is ignored.
REQ-018 in_ready SHALL be 1 only in LOAD_A, LOAD_B and LOAD_C.
REQ-019 A beat accepted in cycle t SHALL produce exactly one TPU write in cycle t+1: tpu_r_w=1, tpu_dataIn=in_data.
REQ-020 LOAD_A beat r (0..DIM-1) SHALL write address 0x100+8r; after DIM beats go to LOAD_B.
REQ-021 LOAD_B beat r SHALL write address 0x200+8r; after DIM beats go to LOAD_C if load_c was latched, else ZERO_C.
REQ-022 LOAD_C beat k (0..2*DIM-1) SHALL write address 0x300+8k (row k>>1; high half when k is odd); after 2*DIM beats go to KICK.
REQ-023 ZERO_C SHALL issue 2*DIM consecutive writes of 0 to 0x300+8k without consuming input, then go to KICK.
REQ-024 KICK SHALL issue one write to 0x400 for exactly one cycle, then go to WAIT.
REQ-025 In every cycle without a commanded access, the port SHALL drive tpu_r_w=0 and tpu_addr=0x000, so the 0x400 address is never held for more than one cycle.
REQ-026 WAIT SHALL last COMP_CYC cycles, counted from the cycle after the 0x400 write, then go to RD_ADDR with k=0.
REQ-027 RD_ADDR SHALL drive tpu_r_w=0 and tpu_addr=0x300+8k for RD_LAT cycles, then capture tpu_dataOut into out_data and go to RD_OUT.
REQ-028 RD_OUT SHALL hold out_valid=1 and keep out_data and tpu_addr stable until out_ready=1.
REQ-029 In RD_OUT, on handshake: if k<2*DIM-1, increment k and go to RD_ADDR; else go to DONE.
REQ-030 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-031 Beat counters SHALL be $clog2(2*DIM)+1 bits and SHALL clear on every state entry; addresses SHALL be formed as base + (counter<<3), truncated to ADDRW.
REQ-032 in_valid=0 in a LOAD state SHALL stall with no TPU write issued; out_ready=0 SHALL stall indefinitely without a re-read.

Reset
REQ-033 While rst=1 the block SHALL be in IDLE with all counters 0.
REQ-034 While rst=1 the outputs SHALL be: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, tpu_r_w=0, tpu_addr=0, tpu_dataIn=0.
REQ-035 Reset asserted mid-job SHALL abort immediately; after release the block SHALL wait for a new start.

Verification
REQ-036 Identity A, B[r]=r+1 bytes, load_c=0, out_ready=1 -> writes 0x100..0x138, 0x200..0x238 and 0x300..0x378 zeros; one 0x400 write; first read exactly COMP_CYC cycles after the 0x400 write; 16 out words equal to B, then done.
REQ-037 in_valid toggling 1-0-1 every cycle during LOAD_A -> exactly 8 A writes at consecutive 8-byte addresses, with no write in gap cycles.
REQ-038 load_c=1, C words 0x0001000100010001 -> results equal A*B+1 per element.
REQ-039 out_ready held 0 for 10 cycles on word 5 -> out_data and tpu_addr 0x328 stable; no duplicate or lost word.
REQ-040 rst pulsed during WAIT -> all outputs 0 next cycle; start after reset runs a full clean job.
REQ-041 start pulsed while busy -> ignored; exactly one done pulse per job.

Source files
------------

// File: rtl/tpu_job_seq_if.sv
// Handshake and TPU command bundle between a job sequencer and its host/TPU.
// The slave modport is the sequencer's view; master is the host/TPU side.
interface tpu_job_seq_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             start;
    logic             load_c;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn;
    logic [DATAW-1:0] tpu_dataOut;

    modport master (
        output start, load_c, in_valid, in_data, out_ready, tpu_dataOut,
        input  busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
    );

    modport slave (
        input  start, load_c, in_valid, in_data, out_ready, tpu_dataOut,
        output busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
    );
endinterface

// File: rtl/tpu_job_seq.sv
// Job sequencer for a memory-mapped systolic TPU: streams A, B and C into the
// TPU, kicks the computation, waits it out, then streams the C result back out.
module tpu_job_seq #(
    parameter int DIM      = 8,
    parameter int ADDRW    = 16,
    parameter int DATAW    = 64,
    parameter int COMP_CYC = 3*DIM-1,
    parameter int RD_LAT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    tpu_job_seq_if.slave  bus
);

    localparam int CW = $clog2(2*DIM) + 1;
    localparam int TW = $clog2(COMP_CYC + RD_LAT + 1) + 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD_A  = 4'd1;
    localparam logic [3:0] S_LOAD_B  = 4'd2;
    localparam logic [3:0] S_LOAD_C  = 4'd3;
    localparam logic [3:0] S_ZERO_C  = 4'd4;
    localparam logic [3:0] S_KICK    = 4'd5;
    localparam logic [3:0] S_WAIT    = 4'd6;
    localparam logic [3:0] S_RD_ADDR = 4'd7;
    localparam logic [3:0] S_RD_OUT  = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    localparam logic [ADDRW-1:0] A_BASE    = ADDRW'(12'h100);
    localparam logic [ADDRW-1:0] B_BASE    = ADDRW'(12'h200);
    localparam logic [ADDRW-1:0] C_BASE    = ADDRW'(12'h300);
    localparam logic [ADDRW-1:0] KICK_ADDR = ADDRW'(12'h400);

    logic [3:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_k;
    logic [TW-1:0]    r_tmr;
    logic             r_load_c;
    logic [DATAW-1:0] r_out_data;
    logic             r_tpu_r_w;
    logic [ADDRW-1:0] r_tpu_addr;
    logic [DATAW-1:0] r_tpu_dataIn;
    logic             w_loading;
    logic             w_last_row;
    logic             w_last_word;

    function automatic logic [ADDRW-1:0] beat_addr(input logic [ADDRW-1:0] base,
                                                   input logic [CW-1:0]    idx);
        return base + (ADDRW'(idx) << 3);
    endfunction

    assign w_loading   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || (r_state == S_LOAD_C);
    assign w_last_row  = (r_cnt == CW'(DIM-1));
    assign w_last_word = (r_cnt == CW'(2*DIM-1));

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.in_ready   = w_loading;
    assign bus.out_valid  = (r_state == S_RD_OUT);
    assign bus.out_data   = r_out_data;
    assign bus.tpu_r_w    = r_tpu_r_w;
    assign bus.tpu_addr   = r_tpu_addr;
    assign bus.tpu_dataIn = r_tpu_dataIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_k          <= '0;
            r_tmr        <= '0;
            r_load_c     <= 1'b0;
            r_out_data   <= '0;
            r_tpu_r_w    <= 1'b0;
            r_tpu_addr   <= '0;
            r_tpu_dataIn <= '0;
        end else begin
            // The command port idles at read/address 0 unless a state below drives it.
            r_tpu_r_w    <= 1'b0;
            r_tpu_addr   <= '0;
            r_tpu_dataIn <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_load_c <= bus.load_c;
                        r_cnt    <= '0;
                        r_state  <= S_LOAD_A;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (bus.in_valid) begin
                        r_tpu_r_w    <= 1'b1;
                        r_tpu_addr   <= beat_addr((r_state == S_LOAD_A) ? A_BASE : B_BASE, r_cnt);
                        r_tpu_dataIn <= bus.in_data;
                        if (w_last_row) begin
                            r_cnt <= '0;
                            if (r_state == S_LOAD_A) r_state <= S_LOAD_B;
                            else                     r_state <= r_load_c ? S_LOAD_C : S_ZERO_C;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_C, S_ZERO_C: begin
                    if (bus.in_valid || (r_state == S_ZERO_C)) begin
                        r_tpu_r_w    <= 1'b1;
                        r_tpu_addr   <= beat_addr(C_BASE, r_cnt);
                        r_tpu_dataIn <= (r_state == S_LOAD_C) ? bus.in_data : '0;
                        if (w_last_word) begin
                            r_cnt   <= '0;
                            r_state <= S_KICK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_KICK: begin
                    r_tpu_r_w  <= 1'b1;
                    r_tpu_addr <= KICK_ADDR;
                    r_tmr      <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // The read address is registered on the way out so it lands exactly COMP_CYC after the kick.
                    if (r_tmr == TW'(COMP_CYC-1)) begin
                        r_tmr      <= '0;
                        r_k        <= '0;
                        r_tpu_addr <= C_BASE;
                        r_state    <= S_RD_ADDR;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    r_tpu_addr <= beat_addr(C_BASE, r_k);
                    if (r_tmr == TW'(RD_LAT-1)) begin
                        r_out_data <= bus.tpu_dataOut;
                        r_tmr      <= '0;
                        r_state    <= S_RD_OUT;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_RD_OUT: begin
                    r_tpu_addr <= beat_addr(C_BASE, r_k);
                    if (bus.out_ready) begin
                        if (r_k == CW'(2*DIM-1)) begin
                            r_tpu_addr <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            r_k        <= r_k + 1'b1;
                            r_tpu_addr <= beat_addr(C_BASE, r_k + 1'b1);
                            r_state    <= S_RD_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_job_seq.sv
// Directed bench for tpu_job_seq: a behavioural TPU memory model plus a table of
// job configurations with hand-computed result values, and reset/abort sequences.
module tb_tpu_job_seq;

    localparam int DIM      = 8;
    localparam int COMP_CYC = 3*DIM-1;

    logic clk;
    logic rst;

    tpu_job_seq_if #(.ADDRW(16), .DATAW(64)) bus ();

    tpu_job_seq #(.DIM(DIM), .ADDRW(16), .DATAW(64), .COMP_CYC(COMP_CYC), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // TPU model: A/B rows of bytes, C rows of two words with four 16-bit elements each.
    logic [63:0] tA [DIM];
    logic [63:0] tB [DIM];
    logic [63:0] tC [2*DIM];

    always @(posedge clk) begin
        if (bus.tpu_r_w) begin
            if (bus.tpu_addr[15:8] == 8'h01)      tA[bus.tpu_addr[5:3]] <= bus.tpu_dataIn;
            else if (bus.tpu_addr[15:8] == 8'h02) tB[bus.tpu_addr[5:3]] <= bus.tpu_dataIn;
            else if (bus.tpu_addr[15:8] == 8'h03) tC[bus.tpu_addr[6:3]] <= bus.tpu_dataIn;
            else if (bus.tpu_addr == 16'h0400) begin
                for (int i = 0; i < DIM; i++) begin
                    for (int j = 0; j < DIM; j++) begin
                        logic [15:0] acc;
                        acc = tC[2*i + j/4][16*(j%4) +: 16];
                        for (int k = 0; k < DIM; k++)
                            acc = acc + 16'(tA[i][8*k +: 8]) * 16'(tB[k][8*j +: 8]);
                        tC[2*i + j/4][16*(j%4) +: 16] <= acc;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.tpu_dataOut = 64'h0;
        if (bus.tpu_addr[15:8] == 8'h03) bus.tpu_dataOut = tC[bus.tpu_addr[6:3]];
    end

    typedef struct {
        logic       load_c;
        logic [7:0] a_diag;
        logic       gap;
        int         stall_word;
        int         stall_len;
        logic       start_busy;
        int         exp_mul;
        int         exp_add;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      64'(bus.busy),       64'h0);
        check({tag, "_done"},      64'(bus.done),       64'h0);
        check({tag, "_in_ready"},  64'(bus.in_ready),   64'h0);
        check({tag, "_out_valid"}, 64'(bus.out_valid),  64'h0);
        check({tag, "_out_data"},  bus.out_data,        64'h0);
        check({tag, "_r_w"},       64'(bus.tpu_r_w),    64'h0);
        check({tag, "_addr"},      64'(bus.tpu_addr),   64'h0);
        check({tag, "_dataIn"},    bus.tpu_dataIn,      64'h0);
    endtask

    task automatic run_job(input vec_t v, input logic abort);
        logic [63:0] beats [4*DIM];
        logic [15:0] ew_addr [4*DIM];
        logic [63:0] ew_data [4*DIM];
        logic [15:0] e;
        int nb, idx, nw, words, kick_cnt, kick_cyc, first_rd, done_cnt, done_cyc;
        int unsol, stall_cnt;
        logic prev_acc, prev_ov, prev_hs;
        logic [63:0] prev_od;
        logic [15:0] prev_addr;

        nb = v.load_c ? 4*DIM : 2*DIM;
        for (int r = 0; r < DIM; r++) begin
            beats[r]       = 64'(v.a_diag) << (8*r);
            beats[DIM + r] = {8{8'(r + 1)}};
            ew_addr[r]       = 16'h0100 + 16'(8*r);
            ew_data[r]       = beats[r];
            ew_addr[DIM + r] = 16'h0200 + 16'(8*r);
            ew_data[DIM + r] = beats[DIM + r];
        end
        for (int k = 0; k < 2*DIM; k++) begin
            beats[2*DIM + k]   = 64'h0001_0001_0001_0001;
            ew_addr[2*DIM + k] = 16'h0300 + 16'(8*k);
            ew_data[2*DIM + k] = v.load_c ? 64'h0001_0001_0001_0001 : 64'h0;
        end

        idx = 0; nw = 0; words = 0; kick_cnt = 0; kick_cyc = -1; first_rd = -1;
        done_cnt = 0; done_cyc = -1; unsol = 0; stall_cnt = 0;
        prev_acc = 1'b0; prev_ov = 1'b0; prev_hs = 1'b0; prev_od = '0; prev_addr = '0;

        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            bus.start    = (c == 0) || (v.start_busy && c == 30);
            bus.load_c   = (c == 0) ? v.load_c : ~v.load_c;
            bus.in_valid = (idx < nb) && !(v.gap && idx < DIM && (c % 2 == 1));
            bus.in_data  = (idx < nb) ? beats[idx] : 64'h0;
            bus.out_ready = !(v.stall_word == words && stall_cnt < v.stall_len);
            if (!bus.out_ready) stall_cnt++;

            @(negedge clk);
            if (c == 1) check("busy_after_start", 64'(bus.busy), 64'h1);
            if (bus.tpu_addr == 16'h0400) kick_cnt++;
            if (bus.tpu_r_w) begin
                if (bus.tpu_addr == 16'h0400) begin
                    if (kick_cyc < 0) kick_cyc = c;
                    check("in_ready_at_kick", 64'(bus.in_ready), 64'h0);
                end else begin
                    if (nw < 4*DIM) begin
                        check("write_addr", 64'(bus.tpu_addr), 64'(ew_addr[nw]));
                        check("write_data", bus.tpu_dataIn, ew_data[nw]);
                    end
                    if (!prev_acc && (bus.tpu_addr < 16'h0300 || v.load_c)) unsol++;
                    nw++;
                end
            end
            if (!bus.tpu_r_w && bus.tpu_addr == 16'h0300 && kick_cyc >= 0 && first_rd < 0)
                first_rd = c;
            if (prev_ov && !prev_hs) begin
                check("stall_data_stable", bus.out_data, prev_od);
                check("stall_addr_stable", 64'(bus.tpu_addr), 64'(prev_addr));
            end
            if (bus.out_valid && !bus.out_ready)
                check("stall_addr", 64'(bus.tpu_addr), 64'(16'h0300 + 16'(8*words)));
            prev_ov = bus.out_valid;
            prev_hs = bus.out_valid && bus.out_ready;
            prev_od = bus.out_data;
            prev_addr = bus.tpu_addr;
            if (bus.out_valid && bus.out_ready) begin
                e = 16'(v.exp_mul * ((words >> 1) + 1) + v.exp_add);
                if (words < 2*DIM) check("out_word", bus.out_data, {4{e}});
                words++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            prev_acc = bus.in_valid && bus.in_ready;
            if (prev_acc) idx++;

            if (abort && kick_cyc >= 0 && c == kick_cyc + 3) begin
                bus.in_valid = 1'b0;
                return;
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;

        check("done_count",     64'(done_cnt), 64'd1);
        check("write_count",    64'(nw),       64'(4*DIM));
        check("unsolicited",    64'(unsol),    64'd0);
        check("kick_cycles",    64'(kick_cnt), 64'd1);
        check("read_latency",   64'(first_rd - kick_cyc), 64'(COMP_CYC));
        check("out_word_count", 64'(words),    64'(2*DIM));
        check("beats_consumed", 64'(idx),      64'(nb));
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'd1, 1'b0, -1, 0,  1'b0, 1, 0};
        vecs[1] = '{1'b0, 8'd1, 1'b1, -1, 0,  1'b0, 1, 0};
        vecs[2] = '{1'b1, 8'd2, 1'b0, -1, 0,  1'b0, 2, 1};
        vecs[3] = '{1'b0, 8'd3, 1'b0,  5, 10, 1'b0, 3, 0};
        vecs[4] = '{1'b1, 8'd1, 1'b0, -1, 0,  1'b1, 1, 1};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.load_c = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 64'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'h0);

        for (int i = 0; i < 5; i++) run_job(vecs[i], 1'b0);

        // Abort during WAIT, then a fresh clean job.
        run_job(vecs[0], 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        check_all_zero("abort_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_abort_busy", 64'(bus.busy), 64'h0);
        check("post_abort_addr", 64'(bus.tpu_addr), 64'h0);
        run_job(vecs[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
